// File: rtl/led_walk_checker_pkg.sv
// rtl/led_walk_checker_pkg.sv - shared walking-light definitions: state encodings, default width, period
package led_walk_checker_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bounce period, shared with the walker: 0..WIDTH-1 up, then WIDTH-2..1 back down.
    function automatic int period(input int width);
        return 2 * width - 2;
    endfunction

endpackage

// File: rtl/led_walk_ref.sv
// rtl/led_walk_ref.sv - combinational phase decoder: expected LED vector, lit index, direction, next phase
module led_walk_ref
    import led_walk_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PH_W  = $clog2(period(DEFAULT_WIDTH)),
    parameter int POS_W = $clog2(DEFAULT_WIDTH)
) (
    input  logic [PH_W-1:0]  phase,
    output logic [WIDTH-1:0] exp_vec,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic [PH_W-1:0]  next_phase
);

    localparam int P = period(WIDTH);

    always_comb begin
        exp_vec    = '0;
        pos        = '0;
        dir        = 1'b0;
        next_phase = '0;
        if (int'(phase) < WIDTH) begin
            pos = POS_W'(int'(phase));
        end else begin
            pos = POS_W'(P - int'(phase));
        end
        exp_vec[pos] = 1'b1;
        dir          = (int'(phase) >= WIDTH - 1);
        next_phase   = (int'(phase) == P - 1) ? '0 : phase + PH_W'(1);
    end

endmodule

// File: rtl/led_walk_checker.sv
// rtl/led_walk_checker.sv - walking-light bus monitor: lock, position, direction, error pulse/count
// Optional first-error capture ports under `define LED_WALK_CAPTURE_EN.
module led_walk_checker
    import led_walk_checker_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int LOCK_LEN = 14,
    parameter int CNT_W    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_ce,
    input  logic [WIDTH-1:0]         i_led,
    output logic                     o_locked,
    output logic [$clog2(WIDTH)-1:0] o_pos,
    output logic                     o_dir,
    output logic                     o_error,
    output logic [CNT_W-1:0]         o_err_count
`ifdef LED_WALK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]         o_cap_exp,
    output logic [WIDTH-1:0]         o_cap_act,
    output logic                     o_cap_valid
`endif
);

    localparam int P     = period(WIDTH);
    localparam int PH_W  = $clog2(P);
    localparam int POS_W = $clog2(WIDTH);
    localparam int MC_W  = $clog2(LOCK_LEN + 1);

    state_t            state;
    logic [PH_W-1:0]   phase;
    logic [MC_W-1:0]   match_cnt;
    logic [WIDTH-1:0]  exp_vec;
    logic [POS_W-1:0]  ref_pos;
    logic              ref_dir;
    logic [PH_W-1:0]   next_phase;
    logic              match;
    logic              is_seed;

    led_walk_ref #(.WIDTH(WIDTH), .PH_W(PH_W), .POS_W(POS_W)) u_ref (
        .phase      (phase),
        .exp_vec    (exp_vec),
        .pos        (ref_pos),
        .dir        (ref_dir),
        .next_phase (next_phase)
    );

    assign match   = (i_led == exp_vec);
    assign is_seed = (i_led == WIDTH'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_SEARCH;
            phase       <= '0;
            match_cnt   <= '0;
            o_locked    <= 1'b0;
            o_pos       <= '0;
            o_dir       <= 1'b0;
            o_error     <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_error <= 1'b0;
            if (i_ce) begin
                case (state)
                    ST_SEARCH: begin
                        if (is_seed) begin
                            state     <= ST_TRACK;
                            phase     <= PH_W'(1);
                            match_cnt <= '0;
                        end
                    end
                    ST_TRACK: begin
                        if (match) begin
                            phase     <= next_phase;
                            match_cnt <= match_cnt + MC_W'(1);
                            if (match_cnt == MC_W'(LOCK_LEN - 1)) begin
                                state    <= ST_LOCKED;
                                o_locked <= 1'b1;
                                o_pos    <= ref_pos;
                                o_dir    <= ref_dir;
                            end
                        end else if (is_seed) begin
                            phase     <= PH_W'(1);
                            match_cnt <= '0;
                        end else begin
                            state <= ST_SEARCH;
                            phase <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            phase <= next_phase;
                            o_pos <= ref_pos;
                            o_dir <= ref_dir;
                        end else begin
                            o_error  <= 1'b1;
                            o_locked <= 1'b0;
                            o_pos    <= '0;
                            o_dir    <= 1'b0;
                            if (o_err_count != '1) begin
                                o_err_count <= o_err_count + CNT_W'(1);
                            end
                            // A stray seed while locked restarts verification immediately.
                            match_cnt <= '0;
                            if (is_seed) begin
                                state <= ST_TRACK;
                                phase <= PH_W'(1);
                            end else begin
                                state <= ST_SEARCH;
                                phase <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= ST_SEARCH;
                        phase <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LED_WALK_CAPTURE_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cap_exp   <= '0;
            o_cap_act   <= '0;
            o_cap_valid <= 1'b0;
        end else if (i_ce && state == ST_LOCKED && !match && !o_cap_valid) begin
            o_cap_exp   <= exp_vec;
            o_cap_act   <= i_led;
            o_cap_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_led_walk_checker.sv
// tb/tb_led_walk_checker.sv - directed bench for led_walk_checker (lock, errors, strobe, saturation, reset)
module tb_led_walk_checker;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_ce = 1'b0;
    logic [7:0] i_led = 8'h00;
    logic       o_locked;
    logic [2:0] o_pos;
    logic       o_dir;
    logic       o_error;
    logic [7:0] o_err_count;
`ifdef LED_WALK_CAPTURE_EN
    logic [7:0] o_cap_exp;
    logic [7:0] o_cap_act;
    logic       o_cap_valid;
`endif

    int tests = 0;
    int failed = 0;

    logic [7:0] pat [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                             8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    int         epos [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};

    led_walk_checker #(.WIDTH(8), .LOCK_LEN(14), .CNT_W(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ce        (i_ce),
        .i_led       (i_led),
        .o_locked    (o_locked),
        .o_pos       (o_pos),
        .o_dir       (o_dir),
        .o_error     (o_error),
        .o_err_count (o_err_count)
`ifdef LED_WALK_CAPTURE_EN
        ,
        .o_cap_exp   (o_cap_exp),
        .o_cap_act   (o_cap_act),
        .o_cap_valid (o_cap_valid)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] led, input logic ce);
        i_led = led;
        i_ce  = ce;
        @(posedge i_clk);
        #1;
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) step(pat[(first + i) % 14], 1'b1);
    endtask

    initial begin
        int k;
        int exp_cnt;

        // Reset state
        #2 i_reset = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_pos", 32'(o_pos), 0);
        chk("rst_error", 32'(o_error), 0);
        chk("rst_count", 32'(o_err_count), 0);
        i_reset = 1'b0;

        // Lock: seed + 13 matches not yet locked, 15th sample locks
        feed(0, 14);
        chk("t1_not_locked_14", 32'(o_locked), 0);
        feed(0, 1);
        chk("t1_locked_15", 32'(o_locked), 1);
        chk("t1_pos", 32'(o_pos), 0);
        chk("t1_dir", 32'(o_dir), 0);
        chk("t1_count", 32'(o_err_count), 0);

        // Strobe gating: position moves only on i_ce=1
        for (int idx = 1; idx <= 14; idx++) begin
            k = idx % 14;
            step(pat[k], 1'b1);
            chk("t3_pos_ce", 32'(o_pos), 32'(epos[k]));
            chk("t3_dir_ce", 32'(o_dir), (k >= 7) ? 1 : 0);
            chk("t3_err_ce", 32'(o_error), 0);
            step(pat[k], 1'b0);
            chk("t3_pos_hold", 32'(o_pos), 32'(epos[k]));
            chk("t3_locked_hold", 32'(o_locked), 1);
        end
        step(8'hFF, 1'b0);
        chk("t3_ignore_locked", 32'(o_locked), 1);
        chk("t3_ignore_err", 32'(o_error), 0);

        // Expected 08, inject 18
        feed(1, 2);
        step(8'h18, 1'b1);
        chk("t2_error", 32'(o_error), 1);
        chk("t2_count", 32'(o_err_count), 1);
        chk("t2_unlocked", 32'(o_locked), 0);
        chk("t2_pos_zero", 32'(o_pos), 0);
        step(8'h00, 1'b0);
        chk("t2_error_pulse", 32'(o_error), 0);
        chk("t2_count_hold", 32'(o_err_count), 1);
`ifdef LED_WALK_CAPTURE_EN
        chk("t2_cap_valid", 32'(o_cap_valid), 1);
        chk("t2_cap_exp", 32'(o_cap_exp), 32'h08);
        chk("t2_cap_act", 32'(o_cap_act), 32'h18);
`endif
        feed(0, 14);
        chk("t2_relock_early", 32'(o_locked), 0);
        feed(0, 1);
        chk("t2_relocked", 32'(o_locked), 1);

        // Locked with phase 5 expected (20), drive seed 01
        feed(1, 4);
        step(8'h01, 1'b1);
        chk("t5_error", 32'(o_error), 1);
        chk("t5_count", 32'(o_err_count), 2);
        chk("t5_unlocked", 32'(o_locked), 0);
        feed(1, 13);
        chk("t5_relock_early", 32'(o_locked), 0);
        feed(0, 1);
        chk("t5_relocked", 32'(o_locked), 1);
        chk("t5_pos", 32'(o_pos), 0);

        // Saturation: 256 more lock/break cycles
        exp_cnt = 2;
        for (int it = 0; it < 256; it++) begin
            step(8'h01, 1'b1);
            if (exp_cnt < 255) exp_cnt++;
            chk("t4_error", 32'(o_error), 1);
            chk("t4_count", 32'(o_err_count), 32'(exp_cnt));
            feed(1, 13);
            feed(0, 1);
        end
        chk("t4_saturated", 32'(o_err_count), 255);
        chk("t4_locked", 32'(o_locked), 1);
`ifdef LED_WALK_CAPTURE_EN
        chk("t4_cap_exp_kept", 32'(o_cap_exp), 32'h08);
        chk("t4_cap_act_kept", 32'(o_cap_act), 32'h18);
`endif

        // Async reset between edges while an error pulse is high
        step(8'h01, 1'b1);
        chk("t6_error_before", 32'(o_error), 1);
        #3 i_reset = 1'b1;
        #1;
        chk("t6_locked", 32'(o_locked), 0);
        chk("t6_error", 32'(o_error), 0);
        chk("t6_count", 32'(o_err_count), 0);
        chk("t6_pos", 32'(o_pos), 0);
`ifdef LED_WALK_CAPTURE_EN
        chk("t6_cap_valid", 32'(o_cap_valid), 0);
`endif
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        feed(1, 14);
        chk("t6_no_lock_without_seed", 32'(o_locked), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
